data_memory_ls: RTL and testbench

DATA_MEMORY_LS -- requirements
Module: data_memory_ls

---
 rtl/data_memory_pkg.sv | 41 ++++
 rtl/data_memory_array.sv | 30 +++
 rtl/data_memory_ls.sv | 124 ++++++++++++
 tb/tb_data_memory_ls.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared definitions for the load/store data memory: access sizes, FSM states
// and the byte-lane decode helpers used by the top level.
package data_memory_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Misaligned halfword/word or the reserved size encoding.
    function automatic logic is_fault(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_B:    be = 4'b0001 << lane;
            SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module data_memory_array #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**AW];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ls.sv
// Load/store data memory: single-cycle byte-lane stores, two-edge loads with
// sign/zero extension, alignment fault detection and a saturating fault counter.
module data_memory_ls
    import data_memory_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic [FCNT_W-1:0] fault_count
);

    state_e              state_q, state_d;
    logic [1:0]          ld_size_q;
    logic                ld_uns_q;
    logic [1:0]          ld_lane_q;
    logic                ld_fault_q;
    logic [31:0]         rdata_q;
    logic                fault_q;
    logic [FCNT_W-1:0]   fcnt_q;

    logic                accept;
    logic                bad;
    logic [3:0]          be;
    logic [31:0]         wdata_lanes;
    logic [31:0]         arr_rdata;
    logic [31:0]         lane_word;
    logic [31:0]         ext_data;

    assign accept = req && (state_q == ST_IDLE);
    assign bad    = is_fault(size, addr[1:0]);
    assign be     = (accept && we && !bad) ? lane_enable(size, addr[1:0]) : 4'b0000;

    // Replicate narrow store data across all lanes; the enables pick the target.
    always_comb begin
        wdata_lanes = wdata;
        case (size)
            SZ_B:    wdata_lanes = {4{wdata[7:0]}};
            SZ_H:    wdata_lanes = {2{wdata[15:0]}};
            default: wdata_lanes = wdata;
        endcase
    end

    data_memory_array #(
        .AW (ADDR_W - 2)
    ) u_array (
        .clk     (clk),
        .addr_i  (addr[ADDR_W-1:2]),
        .be_i    (be),
        .wdata_i (wdata_lanes),
        .re_i    (accept && !we),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        lane_word = arr_rdata >> {ld_lane_q, 3'b000};
        ext_data  = '0;
        case (ld_size_q)
            SZ_B:    ext_data = ld_uns_q ? {24'b0, lane_word[7:0]}
                                         : {{24{lane_word[7]}}, lane_word[7:0]};
            SZ_H:    ext_data = ld_uns_q ? {16'b0, lane_word[15:0]}
                                         : {{16{lane_word[15]}}, lane_word[15:0]};
            SZ_W:    ext_data = arr_rdata;
            default: ext_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !we) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ld_size_q  <= SZ_B;
            ld_uns_q   <= 1'b0;
            ld_lane_q  <= 2'b00;
            ld_fault_q <= 1'b0;
            rdata_q    <= '0;
            fault_q    <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= accept && bad;
            if (accept && bad && (fcnt_q != {FCNT_W{1'b1}})) begin
                fcnt_q <= fcnt_q + FCNT_W'(1);
            end
            if (accept && !we) begin
                ld_size_q  <= size;
                ld_uns_q   <= uns;
                ld_lane_q  <= addr[1:0];
                ld_fault_q <= bad;
            end
            // A faulted load still completes, but always returns zero.
            if (state_q == ST_LOAD) begin
                rdata_q <= ld_fault_q ? 32'h0 : ext_data;
            end
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign rvalid      = (state_q == ST_RESP);
    assign rdata       = rdata_q;
    assign fault       = fault_q;
    assign fault_count = fcnt_q;

endmodule

// File: tb/tb_data_memory_ls.sv
// Directed self-checking bench for data_memory_ls; a second instance with a
// 2-bit fault counter shares the stimulus to exercise counter saturation.
module tb_data_memory_ls;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;

    logic        ready, rvalid, fault;
    logic [31:0] rdata;
    logic [7:0]  fault_count;

    logic        ready2, rvalid2, fault2;
    logic [31:0] rdata2;
    logic [1:0]  fault_count2;

    int checks = 0;
    int errors = 0;

    data_memory_ls #(.ADDR_W(10), .FCNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid),
        .rdata(rdata), .fault(fault), .fault_count(fault_count)
    );

    data_memory_ls #(.ADDR_W(10), .FCNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready2), .rvalid(rvalid2),
        .rdata(rdata2), .fault(fault2), .fault_count(fault_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one request at a negedge, lets the next posedge accept it and
    // returns at the following negedge with req dropped.
    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [9:0] a, input logic [31:0] d);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic doStore(input string tag, input logic [1:0] sz, input logic [9:0] a,
                           input logic [31:0] d, input logic expFault);
        applyStimulus(1'b1, sz, 1'b0, a, d);
        checkOutput({tag, ".fault"}, {31'b0, fault}, {31'b0, expFault});
        checkOutput({tag, ".ready"}, {31'b0, ready}, 32'd1);
    endtask

    task automatic doLoad(input string tag, input logic [1:0] sz, input logic u, input logic [9:0] a,
                          input logic [31:0] expData, input logic expFault);
        applyStimulus(1'b0, sz, u, a, 32'h0);
        checkOutput({tag, ".fault"},   {31'b0, fault},  {31'b0, expFault});
        checkOutput({tag, ".rv_e1"},   {31'b0, rvalid}, 32'd0);
        checkOutput({tag, ".ready_e1"}, {31'b0, ready}, 32'd0);
        @(negedge clk);
        checkOutput({tag, ".rv_e2"},   {31'b0, rvalid}, 32'd1);
        checkOutput({tag, ".rdata"},   rdata,           expData);
        checkOutput({tag, ".fault_e2"}, {31'b0, fault}, 32'd0);
        @(negedge clk);
        checkOutput({tag, ".rv_e3"},   {31'b0, rvalid}, 32'd0);
        checkOutput({tag, ".ready_e3"}, {31'b0, ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst.rvalid", {31'b0, rvalid}, 32'd0);
        checkOutput("rst.rdata", rdata, 32'h0);
        checkOutput("rst.fault", {31'b0, fault}, 32'd0);
        checkOutput("rst.fcnt", {24'b0, fault_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst.ready_after", {31'b0, ready}, 32'd1);

        doStore("sw_dead", 2'b10, 10'h00C, 32'hDEADBEEF, 1'b0);
        doLoad("lw_dead", 2'b10, 1'b0, 10'h00C, 32'hDEADBEEF, 1'b0);

        doStore("sw_zero", 2'b10, 10'h00C, 32'h0000_0000, 1'b0);
        doStore("sb_80", 2'b00, 10'h00D, 32'hFFFF_FF80, 1'b0);
        doLoad("lb_0d", 2'b00, 1'b0, 10'h00D, 32'hFFFFFF80, 1'b0);
        doLoad("lbu_0d", 2'b00, 1'b1, 10'h00D, 32'h00000080, 1'b0);
        doLoad("lw_0c", 2'b10, 1'b0, 10'h00C, 32'h00008000, 1'b0);

        doStore("sw_aaaa", 2'b10, 10'h010, 32'hAAAAAAAA, 1'b0);
        doStore("sh_1234", 2'b01, 10'h012, 32'hFFFF1234, 1'b0);
        doLoad("lw_10", 2'b10, 1'b0, 10'h010, 32'h1234AAAA, 1'b0);
        doLoad("lh_12", 2'b01, 1'b0, 10'h012, 32'h00001234, 1'b0);
        doLoad("lh_10", 2'b01, 1'b0, 10'h010, 32'hFFFFAAAA, 1'b0);
        doLoad("lhu_10", 2'b01, 1'b1, 10'h010, 32'h0000AAAA, 1'b0);

        doStore("sw_0e_bad", 2'b10, 10'h00E, 32'h55555555, 1'b1);
        @(negedge clk);
        checkOutput("fault_pulse_end", {31'b0, fault}, 32'd0);
        doLoad("lh_0b_bad", 2'b01, 1'b0, 10'h00B, 32'h00000000, 1'b1);
        checkOutput("fcnt_2", {24'b0, fault_count}, 32'd2);
        checkOutput("fcnt2_2", {30'b0, fault_count2}, 32'd2);
        doStore("sx_0c_bad", 2'b11, 10'h00C, 32'hFFFFFFFF, 1'b1);
        doStore("sh_11_bad", 2'b01, 10'h011, 32'hFFFFFFFF, 1'b1);
        doStore("sw_0d_bad", 2'b10, 10'h00D, 32'hFFFFFFFF, 1'b1);
        checkOutput("fcnt_5", {24'b0, fault_count}, 32'd5);
        checkOutput("fcnt2_sat", {30'b0, fault_count2}, 32'd3);
        doLoad("lw_0c_kept", 2'b10, 1'b0, 10'h00C, 32'h00008000, 1'b0);
        doLoad("lw_10_kept", 2'b10, 1'b0, 10'h010, 32'h1234AAAA, 1'b0);

        doStore("b2b_sb0", 2'b00, 10'h020, 32'h00000011, 1'b0);
        doStore("b2b_sb1", 2'b00, 10'h021, 32'h00000022, 1'b0);
        doStore("b2b_sh2", 2'b01, 10'h022, 32'h00004433, 1'b0);
        doLoad("lw_20", 2'b10, 1'b0, 10'h020, 32'h44332211, 1'b0);

        applyStimulus(1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
        checkOutput("abort.in_load", {31'b0, ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        checkOutput("abort.rdata", rdata, 32'h0);
        checkOutput("abort.fcnt", {24'b0, fault_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort.ready", {31'b0, ready}, 32'd1);
        checkOutput("abort.rv0", {31'b0, rvalid}, 32'd0);
        @(negedge clk);
        checkOutput("abort.rv1", {31'b0, rvalid}, 32'd0);
        @(negedge clk);
        checkOutput("abort.rv2", {31'b0, rvalid}, 32'd0);
        checkOutput("abort.rdata_hold", rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
